// File: rtl/idelay_load_sched_pkg.sv
// ----------------------------------------------------------------------------
// idelay_load_sched_pkg
// Shared definitions for the IDELAYE2 load scheduler:
//   DLY_W   - width of one IDELAYE2 tap value
//   state_t - scheduler FSM encoding (plain localparam constants)
//   clog2   - ceil(log2(value)) for sizing pointers and counters
// ----------------------------------------------------------------------------
package idelay_load_sched_pkg;

  localparam int DLY_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_APPLY  = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Returns 0 for values <= 1, so callers clamp the result to at least 1 bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/idelay_load_sched_if.sv
// ----------------------------------------------------------------------------
// idelay_load_sched_if
// Write-request channel into the delay load scheduler.
//   wr_valid - request valid (master -> slave)
//   wr_ready - request accepted when high together with wr_valid (slave -> master)
//   wr_lane  - target lane index
//   wr_delay - tap value to load into that lane
// LANE_BITS must match the LANE_BITS of the scheduler it is connected to.
// ----------------------------------------------------------------------------
interface idelay_load_sched_if #(
  parameter int LANE_BITS = 3
);
  import idelay_load_sched_pkg::*;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [LANE_BITS-1:0] wr_lane;
  logic [DLY_W-1:0]     wr_delay;

  modport master (
    output wr_valid,
    output wr_lane,
    output wr_delay,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_lane,
    input  wr_delay,
    output wr_ready
  );

endinterface

// File: rtl/idelay_req_fifo.sv
// ----------------------------------------------------------------------------
// idelay_req_fifo
// Generic synchronous FIFO with full/empty flags and a show-ahead read port.
//   clk, rst_n - clock, asynchronous active-low reset (empties the FIFO)
//   push       - write push_data (ignored when full unless popping the same cycle)
//   pop        - discard the head entry (ignored when empty)
//   pop_data   - current head entry, valid whenever empty is low
//   full       - DEPTH entries stored
//   empty      - no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module idelay_req_fifo
  import idelay_load_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO can still take a new entry when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/idelay_load_sched.sv
// ----------------------------------------------------------------------------
// idelay_load_sched
// Schedules delay updates for IDELAYE2 wrappers in VAR_LOAD_PIPE mode.
// Buffered per-lane writes are serialized onto a shared 5-bit delay bus with a
// one-cycle per-lane load strobe; an apply request then issues one common
// transfer strobe so every lane switches delay on the same clock.
//   clk, rst_n - clock shared with the wrappers, asynchronous active-low reset
//   wr_if      - write-request channel (lane, tap value, valid/ready)
//   apply      - request a common transfer (pulse or level)
//   busy       - work outstanding (sequence running, FIFO non-empty or apply pending)
//   done       - one-cycle pulse at the end of an apply sequence
//   wr_err     - sticky: a write named a lane >= NUM_LANES
//   dly_delay  - shared tap bus to all wrappers
//   dly_ld     - per-lane pipeline-load strobe (at most one-hot)
//   dly_set    - common transfer strobe
//   rd_lane    - shadow readback select
//   rd_delay   - shadow tap value of rd_lane, 0 for lanes that do not exist
// ----------------------------------------------------------------------------
module idelay_load_sched
  import idelay_load_sched_pkg::*;
#(
  parameter int NUM_LANES     = 8,
  parameter int LANE_BITS     = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DELAY_INIT    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  idelay_load_sched_if.slave   wr_if,
  input  logic                 apply,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_err,
  output logic [DLY_W-1:0]     dly_delay,
  output logic [NUM_LANES-1:0] dly_ld,
  output logic                 dly_set,
  input  logic [LANE_BITS-1:0] rd_lane,
  output logic [DLY_W-1:0]     rd_delay
);

  localparam int ENTRY_W     = LANE_BITS + DLY_W;
  localparam int CNT_W       = (clog2(SETTLE_CYCLES + 1) > 0) ? clog2(SETTLE_CYCLES + 1) : 1;
  localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  state_t               state;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 apply_pending;
  logic                 start_apply;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_dout;

  logic [LANE_BITS-1:0] pop_lane;
  logic [DLY_W-1:0]     pop_delay;
  logic [NUM_LANES-1:0] pop_onehot;
  logic                 pop_hit;

  logic [DLY_W-1:0]     shadow [NUM_LANES];

  assign wr_if.wr_ready = !fifo_full;
  assign fifo_push      = wr_if.wr_valid && !fifo_full;
  assign fifo_pop       = (state == ST_IDLE) && !fifo_empty;
  // Queued writes win over apply: a transfer only starts once nothing is left to load.
  assign start_apply    = (state == ST_IDLE) && fifo_empty && apply_pending;

  idelay_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({wr_if.wr_lane, wr_if.wr_delay}),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop_lane  = fifo_dout[DLY_W +: LANE_BITS];
  assign pop_delay = fifo_dout[DLY_W-1:0];

  // Lane decode doubles as the range check: an index past NUM_LANES matches no bit.
  always_comb begin
    pop_onehot = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop_onehot[i] = (pop_lane == LANE_BITS'(i));
    end
  end

  assign pop_hit = |pop_onehot;

  always_comb begin
    rd_delay = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rd_lane == LANE_BITS'(i)) begin
        rd_delay = shadow[i];
      end
    end
  end

  // Load stage: the entry popped this cycle drives the bus and strobe next cycle,
  // and the shadow copy is updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_ld    <= '0;
      dly_delay <= '0;
      wr_err    <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        shadow[i] <= DLY_W'(DELAY_INIT);
      end
    end else begin
      dly_ld <= fifo_pop ? pop_onehot : '0;
      if (fifo_pop && pop_hit) begin
        dly_delay <= pop_delay;
      end
      if (fifo_pop && !pop_hit) begin
        wr_err <= 1'b1;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (fifo_pop && pop_onehot[i]) begin
          shadow[i] <= pop_delay;
        end
      end
    end
  end

  // Apply sequencer. An apply seen on the start cycle (or later) re-arms
  // apply_pending and produces a second full sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      apply_pending <= 1'b0;
    end else begin
      apply_pending <= (apply_pending && !start_apply) || apply;
      case (state)
        ST_IDLE: begin
          if (start_apply) begin
            state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          settle_cnt <= '0;
          state      <= (SETTLE_CYCLES == 0) ? ST_DONE : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == CNT_W'(SETTLE_LAST)) begin
            state <= ST_DONE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dly_set = (state == ST_APPLY);
  assign done    = (state == ST_DONE);
  assign busy    = (state != ST_IDLE) || !fifo_empty || apply_pending;

endmodule

// File: tb/tb_idelay_load_sched.sv
// ----------------------------------------------------------------------------
// tb_idelay_load_sched
// Self-checking bench for idelay_load_sched (8 lanes, 4-bit lane index so that
// out-of-range lanes can be written, depth-4 FIFO, 4 settle cycles, non-zero
// shadow reset value). A transaction-level reference model (request queue plus
// a sequence timeline) predicts every output after each clock edge; fixed
// vector tables and hand-timed sequences pin down the latency corner cases.
// ----------------------------------------------------------------------------
module tb_idelay_load_sched;

  localparam int NL = 8;
  localparam int LB = 4;
  localparam int FD = 4;
  localparam int SC = 4;
  localparam int DI = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          apply = 1'b0;
  logic [LB-1:0] rd_lane = '0;
  logic          busy;
  logic          done;
  logic          wr_err;
  logic          dly_set;
  logic [4:0]    dly_delay;
  logic [4:0]    rd_delay;
  logic [NL-1:0] dly_ld;

  int n_vec;
  int n_err;

  idelay_load_sched_if #(.LANE_BITS(LB)) wr_if ();

  idelay_load_sched #(
    .NUM_LANES     (NL),
    .LANE_BITS     (LB),
    .FIFO_DEPTH    (FD),
    .SETTLE_CYCLES (SC),
    .DELAY_INIT    (DI)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_if     (wr_if),
    .apply     (apply),
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err),
    .dly_delay (dly_delay),
    .dly_ld    (dly_ld),
    .dly_set   (dly_set),
    .rd_lane   (rd_lane),
    .rd_delay  (rd_delay)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests, last bus value, shadow copies, and the
  // position in the apply timeline (-1 idle, 0 transfer, 1..SC settle, SC+1 done).
  typedef struct {
    int lane;
    int val;
  } entry_t;

  entry_t        m_q[$];
  logic [NL-1:0] m_ld;
  int            m_delay;
  bit            m_err;
  int            m_shadow[NL];
  bit            m_pending;
  int            m_pos;

  typedef struct {
    int            lane;
    int            val;
    logic [NL-1:0] exp_ld;
    int            exp_delay;
    bit            exp_err;
    int            exp_rd;
  } vec_t;

  vec_t tbl[5];

  int ev_set[$];
  int ev_done[$];
  int ev_ld_t[$];
  int ev_ld_v[$];

  task automatic modelReset();
    m_q.delete();
    m_ld      = '0;
    m_delay   = 0;
    m_err     = 1'b0;
    m_pending = 1'b0;
    m_pos     = -1;
    for (int i = 0; i < NL; i++) m_shadow[i] = DI;
  endtask

  // Advances the model by one clock edge using the inputs presented before it.
  task automatic modelStep();
    bit     idle;
    bit     pop;
    bit     ready;
    bit     start;
    entry_t e;
    idle  = (m_pos < 0);
    ready = (m_q.size() < FD);
    pop   = idle && (m_q.size() > 0);
    start = idle && (m_q.size() == 0) && m_pending;
    m_ld  = '0;
    if (pop) begin
      e = m_q.pop_front();
      if (e.lane < NL) begin
        m_ld[e.lane]     = 1'b1;
        m_delay          = e.val;
        m_shadow[e.lane] = e.val;
      end else begin
        m_err = 1'b1;
      end
    end
    if (wr_if.wr_valid && ready) begin
      e.lane = int'(wr_if.wr_lane);
      e.val  = int'(wr_if.wr_delay);
      m_q.push_back(e);
    end
    m_pending = (m_pending && !start) || apply;
    if (start)              m_pos = 0;
    else if (m_pos == SC+1) m_pos = -1;
    else if (m_pos >= 0)    m_pos = m_pos + 1;
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    int exp_rd;
    exp_rd = (int'(rd_lane) < NL) ? m_shadow[int'(rd_lane)] : 0;
    checkVal("dly_ld",    int'(dly_ld),         int'(m_ld));
    checkVal("dly_delay", int'(dly_delay),      m_delay);
    checkVal("dly_set",   int'(dly_set),        int'(m_pos == 0));
    checkVal("done",      int'(done),           int'(m_pos == SC+1));
    checkVal("wr_err",    int'(wr_err),         int'(m_err));
    checkVal("wr_ready",  int'(wr_if.wr_ready), int'(m_q.size() < FD));
    checkVal("busy",      int'(busy),           int'((m_pos >= 0) || (m_q.size() > 0) || m_pending));
    checkVal("rd_delay",  int'(rd_delay),       exp_rd);
  endtask

  task automatic applyStimulus(input bit valid, input int lane, input int val, input bit ap);
    wr_if.wr_valid = valid;
    wr_if.wr_lane  = LB'(lane);
    wr_if.wr_delay = 5'(val);
    apply          = ap;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic clearEvents();
    ev_set.delete();
    ev_done.delete();
    ev_ld_t.delete();
    ev_ld_v.delete();
  endtask

  task automatic recordEvents(input int e);
    if (dly_set) ev_set.push_back(e);
    if (done)    ev_done.push_back(e);
    if (dly_ld != '0) begin
      ev_ld_t.push_back(e);
      ev_ld_v.push_back(int'(dly_ld));
    end
  endtask

  function automatic int qAt(input int qv[$], input int i);
    return (qv.size() > i) ? qv[i] : -1;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    applyStimulus(0, 0, 0, 0);
    modelReset();

    tbl[0] = '{lane: 3, val: 17, exp_ld: 8'h08, exp_delay: 17, exp_err: 1'b0, exp_rd: 17};
    tbl[1] = '{lane: 0, val: 1,  exp_ld: 8'h01, exp_delay: 1,  exp_err: 1'b0, exp_rd: 1};
    tbl[2] = '{lane: 7, val: 31, exp_ld: 8'h80, exp_delay: 31, exp_err: 1'b0, exp_rd: 31};
    tbl[3] = '{lane: 5, val: 0,  exp_ld: 8'h20, exp_delay: 0,  exp_err: 1'b0, exp_rd: 0};
    tbl[4] = '{lane: 9, val: 12, exp_ld: 8'h00, exp_delay: 0,  exp_err: 1'b1, exp_rd: 0};

    // Reset state
    #23;
    checkVal("rst_ld",    int'(dly_ld),    0);
    checkVal("rst_set",   int'(dly_set),   0);
    checkVal("rst_done",  int'(done),      0);
    checkVal("rst_delay", int'(dly_delay), 0);
    checkVal("rst_err",   int'(wr_err),    0);
    checkVal("rst_busy",  int'(busy),      0);
    for (int i = 0; i < NL; i++) begin
      rd_lane = LB'(i);
      #1;
      checkVal("rst_rd", int'(rd_delay), DI);
    end
    rd_lane = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single writes into an empty FIFO: one load cycle two cycles after the write
    $display("[TB] single-write table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, tbl[i].lane, tbl[i].val, 0);
      tick();
      applyStimulus(0, 0, 0, 0);
      tick();
      checkVal("tbl_ld",    int'(dly_ld),    int'(tbl[i].exp_ld));
      checkVal("tbl_delay", int'(dly_delay), tbl[i].exp_delay);
      checkVal("tbl_err",   int'(wr_err),    int'(tbl[i].exp_err));
      rd_lane = LB'(tbl[i].lane);
      #1;
      checkVal("tbl_rd", int'(rd_delay), tbl[i].exp_rd);
      tick();
      checkVal("tbl_ld_clear", int'(dly_ld), 0);
    end

    // Burst of four back-to-back writes
    $display("[TB] burst");
    clearEvents();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       applyStimulus(1, 0, 1, 0);
        1:       applyStimulus(1, 1, 2, 0);
        2:       applyStimulus(1, 2, 3, 0);
        3:       applyStimulus(1, 7, 31, 0);
        default: applyStimulus(0, 0, 0, 0);
      endcase
      tick();
      recordEvents(c + 1);
      if (c + 1 == 5) checkVal("burst_last_delay", int'(dly_delay), 31);
    end
    checkVal("burst_ld_n",  ev_ld_t.size(), 4);
    checkVal("burst_t0",    qAt(ev_ld_t, 0), 2);
    checkVal("burst_t3",    qAt(ev_ld_t, 3), 5);
    checkVal("burst_v0",    qAt(ev_ld_v, 0), 8'h01);
    checkVal("burst_v1",    qAt(ev_ld_v, 1), 8'h02);
    checkVal("burst_v2",    qAt(ev_ld_v, 2), 8'h04);
    checkVal("burst_v3",    qAt(ev_ld_v, 3), 8'h80);
    checkVal("err_sticky",  int'(wr_err), 1);

    // Apply issued with the first of two writes: loads first, then transfer
    $display("[TB] apply ordering");
    clearEvents();
    for (int c = 0; c < 14; c++) begin
      case (c)
        0:       applyStimulus(1, 1, 9, 1);
        1:       applyStimulus(1, 2, 10, 0);
        default: applyStimulus(0, 0, 0, 0);
      endcase
      tick();
      recordEvents(c + 1);
    end
    checkVal("ord_ld_n",   ev_ld_t.size(), 2);
    checkVal("ord_ld_a",   qAt(ev_ld_t, 0), 2);
    checkVal("ord_ld_b",   qAt(ev_ld_t, 1), 3);
    checkVal("ord_set_n",  ev_set.size(), 1);
    checkVal("ord_set",    qAt(ev_set, 0), 4);
    checkVal("ord_done_n", ev_done.size(), 1);
    checkVal("ord_done",   qAt(ev_done, 0), 9);

    // Second apply and a FIFO fill during SETTLE
    $display("[TB] apply during settle");
    clearEvents();
    for (int c = 0; c < 24; c++) begin
      case (c)
        0:       applyStimulus(0, 0, 0, 1);
        3:       applyStimulus(1, 4, 20, 1);
        4:       applyStimulus(1, 5, 21, 0);
        5:       applyStimulus(1, 6, 22, 0);
        6:       applyStimulus(1, 0, 23, 0);
        7:       applyStimulus(1, 1, 24, 0);
        default: applyStimulus(0, 0, 0, 0);
      endcase
      tick();
      recordEvents(c + 1);
      if (c + 1 == 7) checkVal("full_ready", int'(wr_if.wr_ready), 0);
      if (c + 1 == 9) checkVal("drain_ready", int'(wr_if.wr_ready), 1);
    end
    checkVal("two_set_n",  ev_set.size(), 2);
    checkVal("two_set0",   qAt(ev_set, 0), 2);
    checkVal("two_set1",   qAt(ev_set, 1), 13);
    checkVal("two_done_n", ev_done.size(), 2);
    checkVal("two_done0",  qAt(ev_done, 0), 7);
    checkVal("two_done1",  qAt(ev_done, 1), 18);
    checkVal("two_ld_n",   ev_ld_t.size(), 4);
    checkVal("two_ld_t0",  qAt(ev_ld_t, 0), 9);
    checkVal("two_ld_v3",  qAt(ev_ld_v, 3), 8'h01);

    // Reset in the middle of SETTLE with a write queued
    $display("[TB] reset mid-settle");
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       applyStimulus(0, 0, 0, 1);
        2:       applyStimulus(1, 2, 7, 0);
        default: applyStimulus(0, 0, 0, 0);
      endcase
      tick();
    end
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkVal("mrst_ld",    int'(dly_ld),    0);
    checkVal("mrst_set",   int'(dly_set),   0);
    checkVal("mrst_done",  int'(done),      0);
    checkVal("mrst_delay", int'(dly_delay), 0);
    checkVal("mrst_err",   int'(wr_err),    0);
    for (int i = 0; i < NL; i++) begin
      rd_lane = LB'(i);
      #1;
      checkVal("mrst_rd", int'(rd_delay), DI);
    end
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkVal("post_rst_done", int'(done), 0);
      checkVal("post_rst_busy", int'(busy), 0);
    end

    // Randomized traffic against the model
    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      int lane;
      lane = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, NL-1))
                                          : int'($urandom_range(NL, 15));
      applyStimulus($urandom_range(0, 1) == 1, lane, int'($urandom_range(0, 31)),
                    $urandom_range(0, 9) == 0);
      rd_lane = LB'($urandom_range(0, 15));
      tick();
    end
    applyStimulus(0, 0, 0, 0);
    for (int c = 0; c < 20; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
